// File: rtl/random_n.sv
// rtl/random_n.sv - draws up to K distinct random (X,Y) centroids from a 16-bit Galois LFSR
// and presents them one at a time on a valid/ready handshake.
module random_n #(
    parameter int COOR_W   = 9,
    parameter int COOR_MAX = 479,
    parameter int MAX_K    = 8,
    parameter int QUAN_W   = 4,
    parameter int IDX_W    = 3
) (
    input  logic              RandomN_clk,
    input  logic              RandomN_rst,
    input  logic              Group_start,
    input  logic [QUAN_W-1:0] Group_quanI,
    input  logic              Seed_load,
    input  logic [15:0]       Seed_val,
    input  logic              Group_ready,
    output logic [COOR_W-1:0] Group_coorX,
    output logic [COOR_W-1:0] Group_coorY,
    output logic [IDX_W-1:0]  Group_idx,
    output logic [QUAN_W-1:0] Group_quanO,
    output logic              Group_valid,
    output logic              Group_busy,
    output logic              Group_done
);

    typedef enum logic [2:0] {
        IDLE,
        GEN_X,
        GEN_Y,
        CHECK,
        OUT,
        DONE
    } state_t;

    localparam logic [15:0]       LFSR_MASK = 16'hB400;
    localparam logic [15:0]       LFSR_INIT = 16'hACE1;
    localparam logic [COOR_W-1:0] CMAX      = COOR_W'(COOR_MAX);
    localparam logic [QUAN_W-1:0] KMAX      = QUAN_W'(MAX_K);

    state_t            state;
    state_t            stateNext;
    logic [15:0]       lfsr;
    logic [15:0]       lfsrStep;
    logic [COOR_W-1:0] cand;
    logic              candOk;
    logic              seedTake;
    logic              startTake;
    logic              match;
    logic              lastIdx;
    logic [QUAN_W-1:0] kEff;
    logic [COOR_W-1:0] coorX;
    logic [COOR_W-1:0] coorY;
    logic [IDX_W-1:0]  idx;
    logic [QUAN_W-1:0] quanO;
    logic [COOR_W-1:0] storeX [MAX_K];
    logic [COOR_W-1:0] storeY [MAX_K];

    assign lfsrStep  = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
    assign cand      = lfsr[COOR_W-1:0];
    assign candOk    = (cand <= CMAX);
    assign seedTake  = (state == IDLE) && Seed_load;
    assign startTake = (state == IDLE) && Group_start && !Seed_load;
    assign kEff      = (Group_quanI > KMAX) ? KMAX : Group_quanI;
    assign lastIdx   = (int'(idx) == int'(quanO) - 1);

    // Only slots filled earlier in this run take part in the duplicate check.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < MAX_K; i++) begin
            if (i < int'(idx) && storeX[i] == coorX && storeY[i] == coorY) begin
                match = 1'b1;
            end
        end
    end

    always_ff @(posedge RandomN_clk or posedge RandomN_rst) begin
        if (RandomN_rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (startTake) stateNext = (kEff == '0) ? DONE : GEN_X;
            GEN_X:   if (candOk) stateNext = GEN_Y;
            GEN_Y:   if (candOk) stateNext = CHECK;
            CHECK:   stateNext = match ? GEN_X : OUT;
            OUT:     if (Group_ready) stateNext = lastIdx ? DONE : GEN_X;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge RandomN_clk or posedge RandomN_rst) begin
        if (RandomN_rst) begin
            lfsr  <= LFSR_INIT;
            coorX <= '0;
            coorY <= '0;
            idx   <= '0;
            quanO <= '0;
            for (int i = 0; i < MAX_K; i++) begin
                storeX[i] <= '0;
                storeY[i] <= '0;
            end
        end else begin
            // A zero seed would lock the LFSR, so it is replaced by the reset value.
            if (seedTake) begin
                lfsr <= (Seed_val == 16'h0000) ? LFSR_INIT : Seed_val;
            end else begin
                lfsr <= lfsrStep;
            end
            if (startTake) begin
                quanO <= kEff;
                idx   <= '0;
            end
            if (state == GEN_X && candOk) coorX <= cand;
            if (state == GEN_Y && candOk) coorY <= cand;
            if (state == CHECK && !match) begin
                for (int i = 0; i < MAX_K; i++) begin
                    if (i == int'(idx)) begin
                        storeX[i] <= coorX;
                        storeY[i] <= coorY;
                    end
                end
            end
            if (state == OUT && Group_ready && !lastIdx) idx <= idx + IDX_W'(1);
        end
    end

    assign Group_coorX = coorX;
    assign Group_coorY = coorY;
    assign Group_idx   = idx;
    assign Group_quanO = quanO;
    assign Group_valid = (state == OUT);
    assign Group_busy  = (state != IDLE);
    assign Group_done  = (state == DONE);

endmodule

// File: tb/tb_random_n.sv
// tb/tb_random_n.sv - self-checking bench for random_n: table-driven runs, randomized runs,
// stall/reset/reproducibility sequences and an exhaustive 2-bit instance.
module tb_random_n;

    localparam int COOR_MAX = 479;
    localparam int MAX_K    = 8;

    typedef struct {
        int quanI;
        int doSeed;
        int seed;
        int readyPct;
        int stallFirst;
        int expK;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  quanI = '0;
    logic        seedLoad = 1'b0;
    logic [15:0] seedVal = '0;
    logic        ready = 1'b0;
    logic [8:0]  coorX, coorY;
    logic [2:0]  idx;
    logic [3:0]  quanO;
    logic        valid, busy, done;

    logic        start2 = 1'b0;
    logic [2:0]  quan2 = '0;
    logic        ready2 = 1'b0;
    logic [1:0]  x2, y2, idx2;
    logic [2:0]  quanO2;
    logic        valid2, busy2, done2;

    int errors = 0;
    int checks = 0;
    int gotX[$];
    int gotY[$];

    always #5 clk = ~clk;

    random_n dut (
        .RandomN_clk(clk), .RandomN_rst(rst), .Group_start(start), .Group_quanI(quanI),
        .Seed_load(seedLoad), .Seed_val(seedVal), .Group_ready(ready),
        .Group_coorX(coorX), .Group_coorY(coorY), .Group_idx(idx), .Group_quanO(quanO),
        .Group_valid(valid), .Group_busy(busy), .Group_done(done)
    );

    random_n #(.COOR_W(2), .COOR_MAX(1), .MAX_K(4), .QUAN_W(3), .IDX_W(2)) dut2 (
        .RandomN_clk(clk), .RandomN_rst(rst), .Group_start(start2), .Group_quanI(quan2),
        .Seed_load(1'b0), .Seed_val(16'h0000), .Group_ready(ready2),
        .Group_coorX(x2), .Group_coorY(y2), .Group_idx(idx2), .Group_quanO(quanO2),
        .Group_valid(valid2), .Group_busy(busy2), .Group_done(done2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reset is raised mid-cycle so the outputs are seen to clear without a clock edge.
    task automatic doReset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_x", int'(coorX), 0);
        chk("rst_y", int'(coorY), 0);
        chk("rst_idx", int'(idx), 0);
        chk("rst_quanO", int'(quanO), 0);
        start = 1'b0;
        seedLoad = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic loadSeed(input int s);
        @(negedge clk);
        seedLoad = 1'b1;
        seedVal = 16'(s);
        start = 1'b1;
        quanI = 4'd4;
        @(negedge clk);
        seedLoad = 1'b0;
        start = 1'b0;
        chk("seed_beats_start", int'(busy), 0);
    endtask

    task automatic runOnce(input int q, input int readyPct, input int stallFirst, input int expK);
        int holdCnt, doneCnt, busyCnt, cyc, dup;
        logic holding, hsPrev, lastPrev;
        int hx, hy;
        gotX.delete();
        gotY.delete();
        holding = 1'b0;
        hsPrev = 1'b0;
        lastPrev = (expK == 0);
        holdCnt = 0;
        doneCnt = 0;
        busyCnt = 0;
        hx = 0;
        hy = 0;
        @(negedge clk);
        start = 1'b1;
        quanI = 4'(q);
        ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 0; cyc < 4000; cyc++) begin
            if (!busy) break;
            busyCnt++;
            if (hsPrev) chk("valid_drop", int'(valid), 0);
            chk("done_timing", int'(done), int'(lastPrev));
            if (done) doneCnt++;
            hsPrev = 1'b0;
            lastPrev = 1'b0;
            if (valid) begin
                if (holding) begin
                    chk("hold_x", int'(coorX), hx);
                    chk("hold_y", int'(coorY), hy);
                    chk("hold_idx", int'(idx), gotX.size());
                end else begin
                    chk("idx_order", int'(idx), gotX.size());
                    chk("x_range", int'(int'(coorX) <= COOR_MAX), 1);
                    chk("y_range", int'(int'(coorY) <= COOR_MAX), 1);
                    dup = 0;
                    foreach (gotX[i]) if (gotX[i] == int'(coorX) && gotY[i] == int'(coorY)) dup = 1;
                    chk("distinct", dup, 0);
                    hx = int'(coorX);
                    hy = int'(coorY);
                    holdCnt = 0;
                end
                holdCnt++;
                if (gotX.size() == 0 && holdCnt <= stallFirst) ready = 1'b0;
                else ready = (int'($urandom_range(0, 99)) < readyPct);
                if (ready) begin
                    gotX.push_back(hx);
                    gotY.push_back(hy);
                    holding = 1'b0;
                    hsPrev = 1'b1;
                    lastPrev = (gotX.size() == expK);
                end else begin
                    holding = 1'b1;
                end
            end else begin
                ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        ready = 1'b0;
        chk("run_terminates", int'(cyc < 4000), 1);
        chk("emit_count", gotX.size(), expK);
        chk("done_pulses", doneCnt, 1);
        chk("quanO_hold", int'(quanO), expK);
        if (expK == 0) chk("k0_busy_cycles", busyCnt, 1);
    endtask

    initial begin
        vec_t vecs[6];
        int refX[$];
        int refY[$];
        int seen[4];
        int q, n, cyc;

        vecs[0] = '{4, 0, 0, 100, 0, 4};
        vecs[1] = '{0, 0, 0, 100, 0, 0};
        vecs[2] = '{15, 0, 0, 70, 0, 8};
        vecs[3] = '{8, 1, 'h1234, 50, 20, 8};
        vecs[4] = '{1, 0, 0, 100, 0, 1};
        vecs[5] = '{9, 1, 0, 60, 0, 8};

        doReset();
        foreach (vecs[i]) begin
            if (vecs[i].doSeed != 0) loadSeed(vecs[i].seed);
            runOnce(vecs[i].quanI, vecs[i].readyPct, vecs[i].stallFirst, vecs[i].expK);
        end

        for (int r = 0; r < 8; r++) begin
            q = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) loadSeed(int'($urandom_range(0, 65535)));
            runOnce(q, int'($urandom_range(30, 100)), int'($urandom_range(0, 5)),
                    (q > MAX_K) ? MAX_K : q);
        end

        doReset();
        loadSeed('h1234);
        runOnce(3, 100, 0, 3);
        refX = gotX;
        refY = gotY;
        doReset();
        loadSeed('h1234);
        runOnce(3, 100, 0, 3);
        chk("repro_len", gotX.size(), refX.size());
        foreach (refX[i]) begin
            if (i < gotX.size()) begin
                chk("repro_x", gotX[i], refX[i]);
                chk("repro_y", gotY[i], refY[i]);
            end
        end

        @(negedge clk);
        start = 1'b1;
        quanI = 4'd5;
        ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 0; cyc < 200 && !valid; cyc++) @(negedge clk);
        chk("reach_out", int'(valid), 1);
        doReset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("abort_no_done", int'(done), 0);
        end
        runOnce(2, 100, 0, 2);

        for (int i = 0; i < 4; i++) seen[i] = 0;
        n = 0;
        doReset();
        @(negedge clk);
        start2 = 1'b1;
        quan2 = 3'd4;
        ready2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (cyc = 0; cyc < 3000 && !done2; cyc++) begin
            if (valid2) begin
                seen[int'(x2) * 2 + int'(y2)]++;
                n++;
            end
            @(negedge clk);
        end
        chk("small_done", int'(done2), 1);
        chk("small_count", n, 4);
        chk("small_quanO", int'(quanO2), 4);
        foreach (seen[i]) chk("small_pair_once", seen[i], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
